// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-input, W-bit registered multiplexer with valid/ready output.
// Two modes: direct select (external sel picks the channel) and auto-scan
// (internal pointer visits channels round-robin, DWELL samples per channel).
// All outputs come straight from flops; reset is synchronous, active-low.
module mux_nx1_scan #(
    parameter  int N     = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 1,
    localparam int SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            mode,
    input  logic [N*W-1:0]  a,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    y,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [SELW-1:0] ch,
    output logic            wrap
);

    // Width of the dwell counter; at least one bit even when DWELL is 1.
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Channel pick; an index outside 0..N-1 yields zero.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus,
                                          input logic [SELW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) begin
                r = bus[k*W +: W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [W-1:0]    y_r,      y_nxt_s;
    logic            valid_r,  valid_nxt_s;
    logic [SELW-1:0] ch_r,     ch_nxt_s;
    logic            wrap_r,   wrap_nxt_s;
    logic [SELW-1:0] ptr_r,    ptr_nxt_s;
    logic [DCW-1:0]  dcnt_r,   dcnt_nxt_s;
    logic            mode_q_r;

    logic            ld_s;
    logic            entry_s;
    logic [SELW-1:0] eff_ptr_s;
    logic [DCW-1:0]  eff_dcnt_s;

    // Load when the output slot is empty or being drained this cycle.
    assign ld_s       = !valid_r || y_ready;
    // Scan entry: the scan state is treated as freshly cleared this cycle.
    assign entry_s    = mode && !mode_q_r;
    assign eff_ptr_s  = entry_s ? '0 : ptr_r;
    assign eff_dcnt_s = entry_s ? '0 : dcnt_r;

    // Next-state for the output register and the scan pointer / dwell count.
    always_comb begin
        y_nxt_s     = y_r;
        valid_nxt_s = valid_r;
        ch_nxt_s    = ch_r;
        wrap_nxt_s  = wrap_r;
        ptr_nxt_s   = eff_ptr_s;
        dcnt_nxt_s  = eff_dcnt_s;
        if (ld_s) begin
            if (!enable) begin
                y_nxt_s     = '0;
                valid_nxt_s = 1'b0;
                wrap_nxt_s  = 1'b0;
            end else if (!mode) begin
                y_nxt_s     = pick(a, sel);
                ch_nxt_s    = sel;
                wrap_nxt_s  = 1'b0;
                valid_nxt_s = 1'b1;
            end else begin
                y_nxt_s     = pick(a, eff_ptr_s);
                ch_nxt_s    = eff_ptr_s;
                valid_nxt_s = 1'b1;
                if (eff_dcnt_s == DCW'(DWELL - 1)) begin
                    dcnt_nxt_s = '0;
                    if (eff_ptr_s == SELW'(N - 1)) begin
                        ptr_nxt_s  = '0;
                        wrap_nxt_s = 1'b1;
                    end else begin
                        ptr_nxt_s  = eff_ptr_s + SELW'(1);
                        wrap_nxt_s = 1'b0;
                    end
                end else begin
                    dcnt_nxt_s = eff_dcnt_s + DCW'(1);
                    wrap_nxt_s = 1'b0;
                end
            end
        end else begin
            y_nxt_s = y_r;
        end
    end

    // State register with synchronous active-low reset; mode_q tracks mode every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_r      <= '0;
            valid_r  <= 1'b0;
            ch_r     <= '0;
            wrap_r   <= 1'b0;
            ptr_r    <= '0;
            dcnt_r   <= '0;
            mode_q_r <= 1'b0;
        end else begin
            y_r      <= y_nxt_s;
            valid_r  <= valid_nxt_s;
            ch_r     <= ch_nxt_s;
            wrap_r   <= wrap_nxt_s;
            ptr_r    <= ptr_nxt_s;
            dcnt_r   <= dcnt_nxt_s;
            mode_q_r <= mode;
        end
    end

    assign y       = y_r;
    assign y_valid = valid_r;
    assign ch      = ch_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Scoreboard bench for mux_nx1_scan: two instances share one stimulus stream
// (A: N=8 W=4 DWELL=2, B: N=6 W=4 DWELL=1). A sample-index reference model
// predicts each loaded sample; a negedge monitor pops and compares on accept.
module tb_mux_nx1_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        y_ready = 1'b0;
    logic [31:0] a = 32'h0;

    logic [3:0] ya, yb;
    logic       ya_valid, yb_valid;
    logic [2:0] cha, chb;
    logic       wrapa, wrapb;

    mux_nx1_scan #(.N(8), .W(4), .DWELL(2)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .a(a),
        .sel(sel), .y(ya), .y_valid(ya_valid), .y_ready(y_ready),
        .ch(cha), .wrap(wrapa));

    mux_nx1_scan #(.N(6), .W(4), .DWELL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .a(a[23:0]),
        .sel(sel), .y(yb), .y_valid(yb_valid), .y_ready(y_ready),
        .ch(chb), .wrap(wrapb));

    always #5 clk = ~clk;

    // Reference state: output-valid, held channel, scan sample index per instance.
    bit         mv [2];
    logic [2:0] mch [2];
    int         sidx [2];
    bit         mq;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         run = 1'b0;
    int         total = 0;
    int         bad = 0;

    // Reference update for one instance at a clock edge; item = {wrap, ch, y}.
    task automatic model_edge(input int i, input bit rn, input bit en, input bit md,
                              input logic [2:0] sl, input bit rdy, input logic [31:0] av);
        int n, dw, c;
        logic [3:0] yv;
        bit wr;
        n  = (i == 0) ? 8 : 6;
        dw = (i == 0) ? 2 : 1;
        if (!rn) begin
            mv[i] = 1'b0; mch[i] = 3'd0; sidx[i] = 0;
            if (i == 0) q0.delete(); else q1.delete();
        end else begin
            if (md && !mq) sidx[i] = 0;
            if (!mv[i] || rdy) begin
                if (!en) begin
                    mv[i] = 1'b0;
                end else begin
                    if (!md) begin
                        c  = int'(sl);
                        yv = (c < n) ? av[c*4 +: 4] : 4'h0;
                        wr = 1'b0;
                    end else begin
                        c  = (sidx[i] / dw) % n;
                        yv = av[c*4 +: 4];
                        wr = ((sidx[i] % (n * dw)) == (n * dw - 1));
                        sidx[i] = (sidx[i] + 1) % (n * dw);
                    end
                    mv[i]  = 1'b1;
                    mch[i] = c[2:0];
                    if (i == 0) q0.push_back({wr, c[2:0], yv});
                    else        q1.push_back({wr, c[2:0], yv});
                end
            end
        end
    endtask

    // Drive one cycle of inputs, then advance both references at the edge.
    task automatic step(input bit rn, input bit en, input bit md,
                        input logic [2:0] sl, input bit rdy, input logic [31:0] av);
        rst_n = rn; enable = en; mode = md; sel = sl; y_ready = rdy; a = av;
        @(posedge clk);
        model_edge(0, rn, en, md, sl, rdy, av);
        model_edge(1, rn, en, md, sl, rdy, av);
        mq = rn ? md : 1'b0;
        #1;
        run = 1'b1;
    endtask

    // Compare one instance's outputs against the reference and its queue.
    task automatic chk(input int i, input logic v, input logic [3:0] yy,
                       input logic [2:0] cc, input logic ww);
        logic [7:0] it;
        int sz;
        total++;
        if (v !== mv[i]) begin
            bad++; $display("FAIL inst%0d y_valid: got %b want %b", i, v, mv[i]);
        end
        total++;
        if (cc !== mch[i]) begin
            bad++; $display("FAIL inst%0d ch: got %0d want %0d", i, cc, mch[i]);
        end
        if (v === 1'b1 && y_ready) begin
            sz = (i == 0) ? q0.size() : q1.size();
            total++;
            if (sz == 0) begin
                bad++; $display("FAIL inst%0d accept: sample presented with empty scoreboard", i);
            end else begin
                it = (i == 0) ? q0.pop_front() : q1.pop_front();
                if ({ww, cc, yy} !== it) begin
                    bad++;
                    $display("FAIL inst%0d sample: got wrap=%b ch=%0d y=%h want wrap=%b ch=%0d y=%h",
                             i, ww, cc, yy, it[7], it[6:4], it[3:0]);
                end
            end
        end else if (v === 1'b0) begin
            total++;
            if ({ww, yy} !== 5'b0) begin
                bad++; $display("FAIL inst%0d idle: got wrap=%b y=%h want 0/0", i, ww, yy);
            end
        end else begin
            it = 8'h0;
        end
    endtask

    // Monitor: checks presented outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            chk(0, ya_valid, ya, cha, wrapa);
            chk(1, yb_valid, yb, chb, wrapb);
        end
    end

    initial begin
        logic [31:0] pat;
        bit md_r;
        pat = 32'h7654_3210;
        // Reset from power-up.
        repeat (2) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, pat);
        // Scan mid-run, stall, then reset while a sample is pending.
        repeat (5) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, pat);
        repeat (2) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, pat);
        step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, pat);
        repeat (4) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, pat);
        // Direct select stepping through every sel value.
        for (int s = 0; s < 8; s++) step(1'b1, 1'b1, 1'b0, 3'(s), 1'b1, pat);
        // Scan from a fresh entry across a full cycle of channel A (wrap included).
        repeat (18) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, pat);
        // Backpressure: fresh entry, run to ch=3 on B, stall 3 cycles, resume.
        step(1'b1, 1'b1, 1'b0, 3'd2, 1'b1, pat);
        repeat (4) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, pat);
        repeat (3) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, pat);
        repeat (3) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, pat);
        // Pause for 2 cycles mid-scan, then resume.
        repeat (2) step(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, pat);
        repeat (3) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, pat);
        // Out-of-range direct select, then re-enter scan with a stale pointer.
        step(1'b1, 1'b1, 1'b0, 3'd7, 1'b1, pat);
        step(1'b1, 1'b1, 1'b0, 3'd6, 1'b1, pat);
        repeat (3) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, pat);
        // Randomized traffic.
        md_r = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) md_r = ~md_r;
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), md_r,
                 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7), $urandom);
        end
        repeat (2) step(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, pat);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
